// File: rtl/cdr_loop_filter.sv
// cdr_loop_filter: majority-vote decimating loop filter driving a wrapping PI code; integral path under CDR_LF_FREQ_PATH_EN
module cdr_loop_filter #(
  parameter int VOTE_LEN = 8,
  parameter int PI_W     = 7,
  parameter int PI_INIT  = 0,
  parameter int KP       = 1,
  parameter int INT_W    = 12,
  parameter int KI_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             dn,
  output logic [PI_W-1:0]  pi_code,
  output logic             code_valid,
  output logic [1:0]       vote_dir,
  output logic [INT_W-1:0] freq_int
);
  localparam int CW = $clog2(VOTE_LEN);
  localparam logic signed [PI_W:0] KP_S = (PI_W+1)'(KP);
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [CW:0] acc_q, acc_d;
  logic signed [CW+1:0] vote, sum;
  logic close, upd;
  logic [1:0] vote_dir_q, vote_dir_d;
  logic pend_q, pend_d;
  logic [PI_W-1:0] pi_code_q, pi_code_d;
  logic code_valid_q, code_valid_d;
  logic signed [PI_W:0] kp_term, step;
`ifdef CDR_LF_FREQ_PATH_EN
  localparam logic signed [INT_W-1:0] FI_MAX = {1'b0, {(INT_W-1){1'b1}}};
  logic signed [INT_W-1:0] freq_int_q, freq_int_d, fi_sh;
`endif
  // vote accumulation, window close decision and update-stage arithmetic
  always_comb begin
    vote = (up & ~dn) ? (CW+2)'(1) : (dn & ~up) ? -(CW+2)'(1) : '0;
    sum = {acc_q[CW], acc_q} + vote;
    close = en && (cnt_q == CW'(VOTE_LEN-1));
    cnt_d = en ? cnt_q + 1'b1 : '0;
    acc_d = (en && !close) ? sum[CW:0] : '0;
    vote_dir_d = close ? {sum > 0, sum < 0} : vote_dir_q;
    pend_d = close;
    upd = pend_q && en;
    kp_term = vote_dir_q[1] ? KP_S : vote_dir_q[0] ? -KP_S : '0;
`ifdef CDR_LF_FREQ_PATH_EN
    fi_sh = freq_int_q >>> KI_SHIFT;
    step = kp_term + fi_sh[PI_W:0];
    freq_int_d = !upd ? freq_int_q
               : (vote_dir_q[1] && freq_int_q != FI_MAX) ? freq_int_q + 1'b1
               : (vote_dir_q[0] && freq_int_q != -FI_MAX) ? freq_int_q - 1'b1
               : freq_int_q;
`else
    step = kp_term;
`endif
    pi_code_d = upd ? pi_code_q + step[PI_W-1:0] : pi_code_q;
    code_valid_d = upd;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      vote_dir_q <= '0;
      pend_q <= 1'b0;
      pi_code_q <= PI_W'(PI_INIT);
      code_valid_q <= 1'b0;
`ifdef CDR_LF_FREQ_PATH_EN
      freq_int_q <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      vote_dir_q <= vote_dir_d;
      pend_q <= pend_d;
      pi_code_q <= pi_code_d;
      code_valid_q <= code_valid_d;
`ifdef CDR_LF_FREQ_PATH_EN
      freq_int_q <= freq_int_d;
`endif
    end
  end
  assign pi_code = pi_code_q;
  assign code_valid = code_valid_q;
  assign vote_dir = vote_dir_q;
`ifdef CDR_LF_FREQ_PATH_EN
  assign freq_int = freq_int_q;
`else
  assign freq_int = '0;
`endif
endmodule
